// File: rtl/uart_pkg.sv
// Shared definitions for the UART command responder: response codes,
// command field positions and the responder FSM state type.
package uart_pkg;

    localparam logic [7:0] UART_ACK    = 8'h06;
    localparam logic [7:0] UART_NAK    = 8'h15;
    localparam int         CMD_WR_BIT  = 7;
    localparam logic [3:0] STATUS_ADDR = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAP_CMD,
        ST_DECODE,
        ST_WAIT_DATA,
        ST_CAP_DATA,
        ST_RESP
    } rsp_state_t;

    // A command is malformed when any of the reserved bits 6:4 is set.
    function automatic logic cmd_malformed(input logic [7:0] cmd);
        return |cmd[6:4];
    endfunction

endpackage

// File: rtl/uart_cmd_regfile.sv
// 8-bit register file behind the command responder. One synchronous write
// port, a combinational read port, the read-only status value at the top
// address and a tap of register 0 for the control output.
module uart_cmd_regfile
    import uart_pkg::*;
#(
    parameter int NREG = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [3:0] waddr,
    input  logic [7:0] wdata,
    input  logic [3:0] raddr,
    output logic [7:0] rdata,
    input  logic [7:0] status_in,
    output logic [7:0] ctrl_out
);

    logic [7:0] regs [NREG];

    // Register writes; the status address is read-only so writes there are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= 8'h00;
            end
        end else if (we && (waddr != STATUS_ADDR)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata    = (raddr == STATUS_ADDR) ? status_in : regs[raddr];
    assign ctrl_out = regs[0];

endmodule

// File: rtl/uart_cmd_responder.sv
// Register-access command responder. Pops command bytes from the receive
// FIFO, executes single-byte register reads/writes and pushes one response
// byte per command into the transmit FIFO.
// Optional feature: define UART_CMD_TIMEOUT_EN to NAK a write whose data
// byte does not arrive within TIMEOUT cycles; without it the FSM waits
// for the data byte indefinitely.
module uart_cmd_responder
    import uart_pkg::*;
#(
    parameter int NREG    = 16,
    parameter int TIMEOUT = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_empty,
    input  logic [7:0] rx_data,
    output logic       rx_rd_en,
    input  logic       tx_full,
    output logic [7:0] tx_data,
    output logic       tx_wr_en,
    input  logic [7:0] status_in,
    output logic [7:0] ctrl_out,
    output logic       busy
);

    rsp_state_t state;
    logic [7:0] cmd;
    logic [7:0] resp;
    logic [7:0] rd_val;
    logic       reg_we;

`ifdef UART_CMD_TIMEOUT_EN
    localparam logic [19:0] TO_LAST = 20'(TIMEOUT - 1);
    logic [19:0] to_cnt;
`endif

    uart_cmd_regfile #(
        .NREG(NREG)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (reg_we),
        .waddr    (cmd[3:0]),
        .wdata    (rx_data),
        .raddr    (cmd[3:0]),
        .rdata    (rd_val),
        .status_in(status_in),
        .ctrl_out (ctrl_out)
    );

    // Responder FSM: command capture, decode, optional data wait, response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            cmd    <= 8'h00;
            resp   <= 8'h00;
`ifdef UART_CMD_TIMEOUT_EN
            to_cnt <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!rx_empty) state <= ST_CAP_CMD;
                end
                ST_CAP_CMD: begin
                    cmd   <= rx_data;
                    state <= ST_DECODE;
                end
                ST_DECODE: begin
                    if (cmd_malformed(cmd)) begin
                        resp  <= UART_NAK;
                        state <= ST_RESP;
                    end else if (!cmd[CMD_WR_BIT]) begin
                        resp  <= rd_val;
                        state <= ST_RESP;
                    end else begin
`ifdef UART_CMD_TIMEOUT_EN
                        to_cnt <= '0;
`endif
                        state <= ST_WAIT_DATA;
                    end
                end
                ST_WAIT_DATA: begin
                    if (!rx_empty) begin
                        state <= ST_CAP_DATA;
`ifdef UART_CMD_TIMEOUT_EN
                    end else if (to_cnt == TO_LAST) begin
                        resp  <= UART_NAK;
                        state <= ST_RESP;
                    end else begin
                        to_cnt <= to_cnt + 20'd1;
`endif
                    end
                end
                ST_CAP_DATA: begin
                    // The register file performs the write this cycle.
                    resp  <= UART_ACK;
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    if (!tx_full) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign reg_we   = (state == ST_CAP_DATA);
    assign rx_rd_en = ((state == ST_IDLE) || (state == ST_WAIT_DATA)) && !rx_empty;
    assign tx_wr_en = (state == ST_RESP) && !tx_full;
    assign tx_data  = resp;
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Self-checking bench for uart_cmd_responder: a receive FIFO model feeds
// command bytes, expected responses are queued when commands are driven
// and compared as the DUT pushes them.
module tb_uart_cmd_responder;

`ifdef UART_CMD_TIMEOUT_EN
    localparam int TB_TIMEOUT = 50;
`else
    localparam int TB_TIMEOUT = 1000000;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_empty;
    logic [7:0] rx_data = 8'h00;
    logic       rx_rd_en;
    logic       tx_full = 1'b0;
    logic [7:0] tx_data;
    logic       tx_wr_en;
    logic [7:0] status_in = 8'h00;
    logic [7:0] ctrl_out;
    logic       busy;

    int checks = 0;
    int failures = 0;

    // Receive FIFO model: test writes rx_mem/n_push, FIFO process owns n_pop.
    logic [7:0] rx_mem [256];
    int n_push = 0;
    int n_pop = 0;
    assign rx_empty = (n_push == n_pop);

    // Scoreboard and monitor state.
    logic [7:0] exp_q [$];
    logic [7:0] m_reg [16];
    int cyc = 0;
    int pop_count = 0;
    int push_count = 0;
    int last_pop_cyc = 0;
    int last_push_cyc = 0;
    logic [7:0] ctrl_at_push = 8'h00;
    logic prev_rd = 1'b0;
    logic prev_wr = 1'b0;

    always #5 clk = ~clk;

    uart_cmd_responder #(
        .NREG   (16),
        .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_empty (rx_empty),
        .rx_data  (rx_data),
        .rx_rd_en (rx_rd_en),
        .tx_full  (tx_full),
        .tx_data  (tx_data),
        .tx_wr_en (tx_wr_en),
        .status_in(status_in),
        .ctrl_out (ctrl_out),
        .busy     (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rx_rd_en && !rx_empty) begin
            rx_data <= rx_mem[n_pop[7:0]];
            n_pop   <= n_pop + 1;
        end
    end

    // Monitor on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_rd_en) begin
                check_eq("rd_when_empty", {31'd0, rx_empty}, 32'd0);
                check_eq("rd_back_to_back", {31'd0, prev_rd}, 32'd0);
                pop_count++;
                last_pop_cyc = cyc;
            end
            if (tx_wr_en) begin
                check_eq("wr_back_to_back", {31'd0, prev_wr}, 32'd0);
                push_count++;
                last_push_cyc = cyc;
                ctrl_at_push = ctrl_out;
                if (exp_q.size() == 0)
                    check_eq("unexpected_push", {24'd0, tx_data}, 32'h100);
                else
                    check_eq("resp_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
            end
        end
        prev_rd = rx_rd_en;
        prev_wr = tx_wr_en;
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_mem[n_push[7:0]] = b;
        n_push = n_push + 1;
    endtask

    task automatic wait_drain(input string tag);
        bit done = 0;
        for (int i = 0; i < 300; i++) begin
            step(1);
            if (exp_q.size() == 0 && !busy && rx_empty) begin
                done = 1;
                break;
            end
        end
        if (!done) check_eq({tag, "_drain"}, 32'd0, 32'd1);
    endtask

    task automatic do_read(input logic [3:0] addr);
        exp_q.push_back((addr == 4'hF) ? status_in : m_reg[addr]);
        push_byte({4'h0, addr});
        wait_drain("read");
    endtask

    task automatic do_write(input logic [3:0] addr, input logic [7:0] data);
        exp_q.push_back(8'h06);
        push_byte({4'h8, addr});
        push_byte(data);
        if (addr != 4'hF) m_reg[addr] = data;
        wait_drain("write");
    endtask

    initial begin
        int pops0;
        int pushes0;
        for (int i = 0; i < 16; i++) m_reg[i] = 8'h00;

        // Reset state
        step(3);
        check_eq("rst_rd_en", {31'd0, rx_rd_en}, 32'd0);
        check_eq("rst_wr_en", {31'd0, tx_wr_en}, 32'd0);
        check_eq("rst_tx_data", {24'd0, tx_data}, 32'h00);
        check_eq("rst_ctrl", {24'd0, ctrl_out}, 32'h00);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        step(2);

        // 1: write register 3, then read it back with latency check
        do_write(4'h3, 8'h5A);
        check_eq("wr_ack_latency", last_push_cyc - last_pop_cyc, 32'd2);
        check_eq("ctrl_after_wr3", {24'd0, ctrl_out}, 32'h00);
        do_read(4'h3);
        check_eq("rd_latency", last_push_cyc - last_pop_cyc, 32'd3);

        // 2: write register 0 drives ctrl_out by the ACK cycle
        do_write(4'h0, 8'hA5);
        check_eq("ctrl_at_ack", {24'd0, ctrl_at_push}, 32'hA5);
        check_eq("ctrl_after_wr0", {24'd0, ctrl_out}, 32'hA5);

        // 3: malformed command, read-only write, status read
        pops0 = pop_count;
        exp_q.push_back(8'h15);
        push_byte(8'h25);
        wait_drain("malformed");
        step(5);
        check_eq("malformed_one_pop", pop_count - pops0, 32'd1);
        do_read(4'h5);
        do_write(4'hF, 8'h11);
        status_in = 8'h3C;
        do_read(4'hF);
        status_in = 8'h00;
        do_read(4'h3);

        // 4: back-pressure holds the response and blocks further pops
        tx_full = 1'b1;
        pops0 = pop_count;
        pushes0 = push_count;
        exp_q.push_back(m_reg[0]);
        push_byte(8'h00);
        exp_q.push_back(m_reg[3]);
        push_byte(8'h03);
        step(20);
        check_eq("full_no_push", push_count - pushes0, 32'd0);
        check_eq("full_one_pop", pop_count - pops0, 32'd1);
        check_eq("full_busy", {31'd0, busy}, 32'd1);
        check_eq("full_tx_data", {24'd0, tx_data}, {24'd0, m_reg[0]});
        tx_full = 1'b0;
        wait_drain("full_release");
        check_eq("full_two_pushes", push_count - pushes0, 32'd2);

        // 5: write with no data byte
        pushes0 = push_count;
`ifdef UART_CMD_TIMEOUT_EN
        exp_q.push_back(8'h15);
        push_byte(8'h82);
        wait_drain("timeout");
        check_eq("timeout_push", push_count - pushes0, 32'd1);
        check_eq("timeout_latency", last_push_cyc - last_pop_cyc, 32'd53);
        do_read(4'h2);
`else
        push_byte(8'h82);
        step(1000);
        check_eq("no_timeout_push", push_count - pushes0, 32'd0);
        check_eq("no_timeout_busy", {31'd0, busy}, 32'd1);
        exp_q.push_back(8'h06);
        push_byte(8'h77);
        m_reg[2] = 8'h77;
        wait_drain("late_data");
        do_read(4'h2);
`endif

        // 6: reset while waiting for write data abandons the command
        push_byte(8'h80);
        step(6);
        check_eq("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("arst_busy", {31'd0, busy}, 32'd0);
        check_eq("arst_rd_en", {31'd0, rx_rd_en}, 32'd0);
        check_eq("arst_wr_en", {31'd0, tx_wr_en}, 32'd0);
        check_eq("arst_tx_data", {24'd0, tx_data}, 32'h00);
        check_eq("arst_ctrl", {24'd0, ctrl_out}, 32'h00);
        for (int i = 0; i < 16; i++) m_reg[i] = 8'h00;
        step(2);
        rst = 1'b0;
        step(2);
        do_read(4'h0);
        do_read(4'h3);

        check_eq("leftover_expected", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
